// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS boot/run sequencer.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALT    = 3'd4,
    ST_ERROR   = 3'd5
  } boot_state_t;

  localparam logic [31:0] SYSCALL_INSTR = 32'h0000000C;
  localparam logic [31:0] EXIT_V0       = 32'h0000000A;

  // The exit syscall is a plain syscall with $v0 holding the exit service code.
  function automatic logic is_exit_syscall(input logic [31:0] instr, input logic [31:0] v0);
    return (instr == SYSCALL_INSTR) && (v0 == EXIT_V0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  // Clear wins over enable; once all-ones the count holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot/run sequencer: holds the core in reset, streams an image into imem,
// releases the core, counts run cycles and stops it on the exit syscall.
module mips_boot_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned BOOT_BASE      = 0,
  parameter int unsigned RELEASE_CYCLES = 2,
  parameter int unsigned CYC_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  input  logic [31:0]       cpu_instr,
  input  logic [31:0]       cpu_v0,
  output logic              cpu_reset,
  output logic              cpu_stall,
  output logic              busy,
  output logic              halted,
  output logic              err_overflow,
  output logic [ADDR_W:0]   load_count,
  output logic [CYC_W-1:0]  run_cycles,
  output boot_state_t       dbg_state
);

  // Loader handshake: a word is accepted in a cycle iff load_valid && load_ready.
  // load_ready is high for the whole LOAD state and never depends on load_valid;
  // the producer must hold load_data/load_last stable while load_valid is high
  // and not yet accepted. An accepted word is written to imem in the same cycle.

  localparam logic [ADDR_W:0]   LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BOOT_BASE);
  localparam logic [3:0]        REL_LOAD  = 4'(RELEASE_CYCLES - 1);

  boot_state_t     state, state_d;
  logic [ADDR_W:0] load_count_d;
  logic [3:0]      rel_cnt, rel_cnt_d;
  logic            accept;
  logic            run_clear;
  logic            run_enable;

  // State, load word counter and release countdown registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      load_count <= '0;
      rel_cnt    <= '0;
    end else begin
      state      <= state_d;
      load_count <= load_count_d;
      rel_cnt    <= rel_cnt_d;
    end
  end

  // Next-state logic plus output decode; outputs other than the imem write
  // port are pure decodes of the registered state.
  always_comb begin
    state_d      = state;
    load_count_d = load_count;
    rel_cnt_d    = rel_cnt;
    accept       = 1'b0;
    run_clear    = 1'b0;

    case (state)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (start) begin
          state_d      = ST_LOAD;
          load_count_d = '0;
          run_clear    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          accept       = 1'b1;
          load_count_d = load_count + COUNT_ONE;
          if (load_last) begin
            state_d   = ST_RELEASE;
            rel_cnt_d = REL_LOAD;
          end else if (load_count == LAST_SLOT) begin
            // Image filled every slot but did not say it was finished.
            state_d = ST_ERROR;
          end
        end
      end
      ST_RELEASE: begin
        if (rel_cnt == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          rel_cnt_d = rel_cnt - 4'd1;
        end
      end
      ST_RUN: begin
        if (is_exit_syscall(cpu_instr, cpu_v0)) begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    load_ready   = (state == ST_LOAD);
    imem_wr_en   = accept;
    imem_wr_addr = BASE_ADDR + load_count[ADDR_W-1:0];
    imem_wr_data = load_data;
    run_enable   = (state == ST_RUN);
    cpu_reset    = (state == ST_IDLE) || (state == ST_LOAD) ||
                   (state == ST_RELEASE) || (state == ST_ERROR);
    cpu_stall    = (state == ST_HALT);
    busy         = (state == ST_LOAD) || (state == ST_RELEASE);
    halted       = (state == ST_HALT);
    err_overflow = (state == ST_ERROR);
    dbg_state    = state;
  end

  sat_counter #(.W(CYC_W)) u_run_cycles (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (run_clear),
    .enable (run_enable),
    .count  (run_cycles)
  );

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Self-checking bench for mips_boot_ctrl: random image words and run traces
// checked against expectations derived from the boot/run rules.
module tb_mips_boot_ctrl;
  import mips_pkg::*;

  localparam int ADDR_W    = 3;
  localparam int BOOT_BASE = 0;
  localparam int REL_CYC   = 2;
  localparam int CYC_W     = 4;
  localparam int EW        = ADDR_W + 32;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int SAT       = (1 << CYC_W) - 1;

  logic              clk;
  logic              reset;
  logic              start;
  logic              load_valid;
  logic              load_ready;
  logic [31:0]       load_data;
  logic              load_last;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;
  logic [31:0]       cpu_instr;
  logic [31:0]       cpu_v0;
  logic              cpu_reset;
  logic              cpu_stall;
  logic              busy;
  logic              halted;
  logic              err_overflow;
  logic [ADDR_W:0]   load_count;
  logic [CYC_W-1:0]  run_cycles;
  boot_state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  mips_boot_ctrl #(
    .ADDR_W(ADDR_W), .BOOT_BASE(BOOT_BASE), .RELEASE_CYCLES(REL_CYC), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .cpu_instr(cpu_instr), .cpu_v0(cpu_v0), .cpu_reset(cpu_reset), .cpu_stall(cpu_stall),
    .busy(busy), .halted(halted), .err_overflow(err_overflow),
    .load_count(load_count), .run_cycles(run_cycles), .dbg_state(dbg_state)
  );

  // Clock and timeout guard.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives image words first_k..n-1; gap_mode 0 = always valid, 1 = toggle, 2 = random.
  task automatic drive_load(input int first_k, input int n, input bit with_last,
                            input int gap_mode, input bit fixed_data);
    int k;
    int cyc;
    logic v;
    logic [31:0] d;
    logic [EW-1:0] exp_w;
    logic [EW-1:0] got_w;
    logic [ADDR_W:0] exp_lc;
    k = first_k;
    cyc = 0;
    while (k < n && cyc < 200) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = fixed_data ? 32'(32'h11 * (k + 1)) : $urandom;
      load_valid = v;
      load_data  = d;
      load_last  = with_last && (k == n - 1);
      if (v) exp_q.push_back({ADDR_W'((BOOT_BASE + k) % DEPTH), d});
      #1;
      checks++;
      if (load_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready: got %b expected 1 (word %0d)", load_ready, k);
      end
      checks++;
      if (imem_wr_en !== v) begin
        errors++;
        $display("FAIL imem_wr_en: got %b expected %b (word %0d)", imem_wr_en, v, k);
      end else if (v) begin
        got_w = {imem_wr_addr, imem_wr_data};
        exp_w = exp_q.pop_front();
        checks++;
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL imem_write: got addr %0d data %h expected addr %0d data %h",
                   got_w[EW-1:32], got_w[31:0], exp_w[EW-1:32], exp_w[31:0]);
        end
      end
      tick();
      if (v) k++;
      cyc++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL load_budget: accepted %0d of %0d words", k, n);
    end
    exp_lc = n[ADDR_W:0];
    checks++;
    if (load_count !== exp_lc) begin
      errors++;
      $display("FAIL load_count: got %0d expected %0d", load_count, exp_lc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover writes expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Counts cycles with the core held in reset after the final image word.
  task automatic wait_release();
    int n;
    n = 0;
    while (cpu_reset === 1'b1 && n < 20) begin
      checks++;
      if (busy !== 1'b1 || load_ready !== 1'b0) begin
        errors++;
        $display("FAIL release_flags: got busy %b load_ready %b expected 1 0", busy, load_ready);
      end
      n++;
      tick();
    end
    checks++;
    if (n != REL_CYC) begin
      errors++;
      $display("FAIL release_len: got %0d cycles expected %0d", n, REL_CYC);
    end
    checks++;
    if (cpu_stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_entry: got stall %b busy %b expected 0 0", cpu_stall, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    cpu_instr = '0; cpu_v0 = '0;
    repeat (2) tick();
    checks++;
    if (cpu_reset !== 1'b1 || cpu_stall !== 1'b0 || load_ready !== 1'b0 || imem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rst %b stall %b rdy %b wr %b expected 1 0 0 0",
               cpu_reset, cpu_stall, load_ready, imem_wr_en);
    end
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy %b halted %b err %b expected 0 0 0", busy, halted, err_overflow);
    end
    checks++;
    if (load_count !== '0 || run_cycles !== '0) begin
      errors++;
      $display("FAIL reset_counts: got load %0d run %0d expected 0 0", load_count, run_cycles);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_start_valid_idle();
    start = 1'b1;
    load_valid = 1'b1;
    load_data = $urandom;
    #1;
    checks++;
    if (imem_wr_en !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_accept: got wr %b rdy %b expected 0 0", imem_wr_en, load_ready);
    end
    tick();
    start = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || load_count !== '0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL enter_load: got busy %b count %0d rst %b expected 1 0 1", busy, load_count, cpu_reset);
    end
  endtask

  // Runs the core until the exit syscall on cycle n_exit; a start pulse and a
  // syscall with the wrong $v0 are mixed in and must have no effect.
  task automatic test_run(input int n_exit);
    int exp_cnt;
    for (int k = 1; k <= n_exit; k++) begin
      start = (k == 2);
      if (k == n_exit) begin
        cpu_instr = 32'h0000000C;
        cpu_v0 = 32'h0000000A;
      end else if (k == 5) begin
        cpu_instr = 32'h0000000C;
        cpu_v0 = 32'h00000001;
      end else begin
        cpu_instr = $urandom;
        if (cpu_instr == 32'h0000000C) cpu_instr = 32'h0;
        cpu_v0 = 32'($urandom_range(0, 15));
      end
      tick();
      start = 1'b0;
      exp_cnt = (k > SAT) ? SAT : k;
      checks++;
      if (run_cycles !== CYC_W'(exp_cnt)) begin
        errors++;
        $display("FAIL run_cycles: got %0d expected %0d (cycle %0d)", run_cycles, exp_cnt, k);
      end
      checks++;
      if (halted !== (k == n_exit) || cpu_reset !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL run_state: got halted %b rst %b busy %b expected %b 0 0 (cycle %0d)",
                 halted, cpu_reset, busy, (k == n_exit), k);
      end
    end
    exp_cnt = (n_exit > SAT) ? SAT : n_exit;
    for (int j = 0; j < 3; j++) begin
      cpu_instr = $urandom;
      cpu_v0 = $urandom;
      tick();
      checks++;
      if (run_cycles !== CYC_W'(exp_cnt) || cpu_stall !== 1'b1 || cpu_reset !== 1'b0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold: got cyc %0d stall %b rst %b halted %b expected %0d 1 0 1",
                 run_cycles, cpu_stall, cpu_reset, halted, exp_cnt);
      end
    end
  endtask

  task automatic test_restart_from_halt();
    pulse_start();
    checks++;
    if (cpu_reset !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b1 || halted !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL restart_ctrl: got rst %b busy %b rdy %b halted %b stall %b expected 1 1 1 0 0",
               cpu_reset, busy, load_ready, halted, cpu_stall);
    end
    checks++;
    if (load_count !== '0 || run_cycles !== '0) begin
      errors++;
      $display("FAIL restart_counts: got load %0d run %0d expected 0 0", load_count, run_cycles);
    end
  endtask

  task automatic test_basic_load();
    drive_load(0, 4, 1'b1, 0, 1'b1);
    wait_release();
  endtask

  task automatic test_load_gaps();
    drive_load(0, 2, 1'b0, 1, 1'b0);
    pulse_start();
    checks++;
    if (load_count !== 4'd2 || busy !== 1'b1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_load: got count %0d busy %b rdy %b expected 2 1 1", load_count, busy, load_ready);
    end
    drive_load(2, 4, 1'b1, 1, 1'b0);
    wait_release();
  endtask

  task automatic test_overflow();
    pulse_start();
    drive_load(0, DEPTH, 1'b0, 2, 1'b0);
    checks++;
    if (err_overflow !== 1'b1 || cpu_reset !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_ERROR) begin
      errors++;
      $display("FAIL overflow_flags: got err %b rst %b busy %b state %0d expected 1 1 0 %0d",
               err_overflow, cpu_reset, busy, dbg_state, ST_ERROR);
    end
    for (int j = 0; j < 3; j++) begin
      load_valid = 1'b1;
      load_data = $urandom;
      #1;
      checks++;
      if (imem_wr_en !== 1'b0 || load_ready !== 1'b0) begin
        errors++;
        $display("FAIL error_no_write: got wr %b rdy %b expected 0 0", imem_wr_en, load_ready);
      end
      tick();
    end
    load_valid = 1'b0;
    checks++;
    if (err_overflow !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: got err %b rst %b expected 1 1", err_overflow, cpu_reset);
    end
    pulse_start();
    checks++;
    if (err_overflow !== 1'b0 || busy !== 1'b1 || load_count !== '0) begin
      errors++;
      $display("FAIL error_recover: got err %b busy %b count %0d expected 0 1 0", err_overflow, busy, load_count);
    end
    drive_load(0, 3, 1'b1, 2, 1'b0);
    wait_release();
  endtask

  task automatic test_reset_mid_load();
    load_valid = 1'b1;
    load_data = $urandom;
    #1;
    checks++;
    if (imem_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort_write: got %b expected 1", imem_wr_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_wr_en !== 1'b0 || load_ready !== 1'b0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL async_abort: got wr %b rdy %b busy %b rst %b expected 0 0 0 1",
               imem_wr_en, load_ready, busy, cpu_reset);
    end
    checks++;
    if (load_count !== '0 || run_cycles !== '0) begin
      errors++;
      $display("FAIL abort_counts: got load %0d run %0d expected 0 0", load_count, run_cycles);
    end
    load_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL post_abort_idle: got busy %b state %0d expected 0 %0d", busy, dbg_state, ST_IDLE);
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_start_valid_idle();
    test_basic_load();
    test_run(10);
    test_restart_from_halt();
    test_load_gaps();
    test_run($urandom_range(6, 12));
    test_overflow();
    test_run(20);
    test_restart_from_halt();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
